// File: rtl/nf10_rbs_reg_node.sv
// ---------------------------------------------------------------------------
// nf10_rbs_reg_node
//
// One register node on the register bus ring. Each cycle the node looks at
// the word arriving from upstream and re-issues it downstream one cycle
// later. When an un-acknowledged request falls inside this node's address
// window, the node services it: writes load a software register, and reads
// replace the data field with the register contents. In both cases the
// request is marked acknowledged. Everything else passes through untouched.
//
// Address map inside the window (offset = low C_ADDR_BITS of the address):
//   0 .. C_NUM_RW-1                   read/write registers (RW_REGS)
//   C_NUM_RW .. C_NUM_RW+C_NUM_RO-1   read-only words (RO_REGS)
//   remaining offsets                 unmapped: reads return 32'hDEAD_BEEF
//
// Ports
//   S_AXI_ACLK      clock
//   S_AXI_ARESETN   asynchronous active-low reset
//   S_RBS_*         ring inputs from the upstream node
//   M_RBS_*         registered ring outputs to the downstream node
//   RW_REGS         RW register contents, register k at [32k+31:32k]
//   WR_STROBE       one-cycle pulse per RW register written, aligned with
//                   the new RW_REGS value
//   RO_REGS         read-only words supplied by user logic
//   RD_STROBE       one-cycle pulse per RO word read, aligned with the ACK
// ---------------------------------------------------------------------------
module nf10_rbs_reg_node #(
  parameter int          C_RBS_SRC_WIDTH = 2,
  parameter logic [29:0] C_BASE_ADDR     = 30'h0,
  parameter int          C_ADDR_BITS     = 4,
  parameter int          C_NUM_RW        = 4,
  parameter int          C_NUM_RO        = 4
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,

  input  logic                         S_RBS_REQ,
  input  logic                         S_RBS_ACK,
  input  logic                         S_RBS_RD_WR_L,
  input  logic [29:0]                  S_RBS_ADDR,
  input  logic [31:0]                  S_RBS_DATA,
  input  logic [C_RBS_SRC_WIDTH-1:0]   S_RBS_SRC,

  output logic                         M_RBS_REQ,
  output logic                         M_RBS_ACK,
  output logic                         M_RBS_RD_WR_L,
  output logic [29:0]                  M_RBS_ADDR,
  output logic [31:0]                  M_RBS_DATA,
  output logic [C_RBS_SRC_WIDTH-1:0]   M_RBS_SRC,

  output logic [32*C_NUM_RW-1:0]       RW_REGS,
  output logic [C_NUM_RW-1:0]          WR_STROBE,
  input  logic [32*C_NUM_RO-1:0]       RO_REGS,
  output logic [C_NUM_RO-1:0]          RD_STROBE
);

  localparam int          C_NUM_MAP       = C_NUM_RW + C_NUM_RO;
  localparam logic [31:0] C_UNMAPPED_DATA = 32'hDEAD_BEEF;

  // -------------------------------------------------------------------------
  // Request decode
  // -------------------------------------------------------------------------
  logic                   w_pending;
  logic                   w_hit;
  logic                   w_rd;
  logic                   w_wr;
  logic [C_ADDR_BITS-1:0] w_offset;
  logic [31:0]            w_off_ext;
  logic                   w_off_rw;
  logic                   w_off_ro;

  assign w_pending = S_RBS_REQ & ~S_RBS_ACK;
  assign w_hit     = w_pending &
                     (S_RBS_ADDR[29:C_ADDR_BITS] == C_BASE_ADDR[29:C_ADDR_BITS]);
  assign w_rd      = w_hit &  S_RBS_RD_WR_L;
  assign w_wr      = w_hit & ~S_RBS_RD_WR_L;
  assign w_offset  = S_RBS_ADDR[C_ADDR_BITS-1:0];

  // Offsets are compared at 32 bits so that a fully populated window
  // (C_NUM_MAP == 2**C_ADDR_BITS) does not wrap the range limits to zero.
  assign w_off_ext = 32'(w_offset);
  assign w_off_rw  = (w_off_ext < 32'(C_NUM_RW));
  assign w_off_ro  = !w_off_rw && (w_off_ext < 32'(C_NUM_MAP));

  // -------------------------------------------------------------------------
  // RW registers. Each register contributes its value to a flat vector only
  // when selected, so the read mux below is a plain OR of the gated words.
  // -------------------------------------------------------------------------
  logic [C_NUM_RW-1:0]    w_wr_stb;
  logic [32*C_NUM_RW-1:0] w_rw_terms;

  for (genvar g = 0; g < C_NUM_RW; g++) begin : g_rw
    logic [31:0] r_rw;
    logic        w_sel;

    assign w_sel       = (w_off_ext == 32'(g));
    assign w_wr_stb[g] = w_wr & w_sel;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        r_rw <= '0;
      end else if (w_wr_stb[g]) begin
        r_rw <= S_RBS_DATA;
      end
    end

    assign w_rw_terms[32*g +: 32] = w_sel ? r_rw : '0;
    assign RW_REGS[32*g +: 32]    = r_rw;
  end

  // -------------------------------------------------------------------------
  // RO words, sampled from user logic in the hit cycle.
  // -------------------------------------------------------------------------
  logic [C_NUM_RO-1:0]    w_rd_stb;
  logic [32*C_NUM_RO-1:0] w_ro_terms;

  for (genvar j = 0; j < C_NUM_RO; j++) begin : g_ro
    logic w_sel;

    assign w_sel       = (w_off_ext == 32'(C_NUM_RW + j));
    assign w_rd_stb[j] = w_rd & w_sel;
    assign w_ro_terms[32*j +: 32] = w_sel ? RO_REGS[32*j +: 32] : '0;
  end

  logic [31:0] w_rw_rdata;
  logic [31:0] w_ro_rdata;

  always_comb begin
    w_rw_rdata = '0;
    for (int unsigned k = 0; k < C_NUM_RW; k++) begin
      w_rw_rdata = w_rw_rdata | w_rw_terms[32*k +: 32];
    end
  end

  always_comb begin
    w_ro_rdata = '0;
    for (int unsigned k = 0; k < C_NUM_RO; k++) begin
      w_ro_rdata = w_ro_rdata | w_ro_terms[32*k +: 32];
    end
  end

  // -------------------------------------------------------------------------
  // Outgoing data: only read hits replace the data field.
  // -------------------------------------------------------------------------
  logic [31:0] w_m_data;

  always_comb begin
    w_m_data = S_RBS_DATA;
    if (w_rd) begin
      if (w_off_rw) begin
        w_m_data = w_rw_rdata;
      end else if (w_off_ro) begin
        w_m_data = w_ro_rdata;
      end else begin
        w_m_data = C_UNMAPPED_DATA;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Ring output stage and strobes, all registered.
  // -------------------------------------------------------------------------
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      M_RBS_REQ     <= 1'b0;
      M_RBS_ACK     <= 1'b0;
      M_RBS_RD_WR_L <= 1'b0;
      M_RBS_ADDR    <= '0;
      M_RBS_DATA    <= '0;
      M_RBS_SRC     <= '0;
      WR_STROBE     <= '0;
      RD_STROBE     <= '0;
    end else begin
      M_RBS_REQ     <= S_RBS_REQ;
      M_RBS_ACK     <= S_RBS_ACK | w_hit;
      M_RBS_RD_WR_L <= S_RBS_RD_WR_L;
      M_RBS_ADDR    <= S_RBS_ADDR;
      M_RBS_DATA    <= w_m_data;
      M_RBS_SRC     <= S_RBS_SRC;
      WR_STROBE     <= w_wr_stb;
      RD_STROBE     <= w_rd_stb;
    end
  end

endmodule

// File: tb/tb_nf10_rbs_reg_node.sv
// ---------------------------------------------------------------------------
// tb_nf10_rbs_reg_node
//
// Drives one ring word per clock and compares every registered output one
// cycle later against a reference model of the node built from arrays and
// integer arithmetic. Directed scenarios are followed by random traffic
// biased towards the node's own address window, then a mid-write reset.
// ---------------------------------------------------------------------------
module tb_nf10_rbs_reg_node;

  localparam logic [29:0] BASE = 30'h100;
  localparam int          NRW  = 4;
  localparam int          NRO  = 4;

  logic         clk;
  logic         rst_n;
  logic         s_req, s_ack, s_rdwr;
  logic [29:0]  s_addr;
  logic [31:0]  s_data;
  logic [1:0]   s_src;
  logic         m_req, m_ack, m_rdwr;
  logic [29:0]  m_addr;
  logic [31:0]  m_data;
  logic [1:0]   m_src;
  logic [127:0] rw_regs;
  logic [3:0]   wr_strobe;
  logic [127:0] ro_regs;
  logic [3:0]   rd_strobe;

  int n_assert;
  int n_fail;

  // Reference state: the four RW registers.
  logic [31:0] rw_m [NRW];

  nf10_rbs_reg_node #(
    .C_RBS_SRC_WIDTH (2),
    .C_BASE_ADDR     (BASE),
    .C_ADDR_BITS     (4),
    .C_NUM_RW        (NRW),
    .C_NUM_RO        (NRO)
  ) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .S_RBS_REQ     (s_req),
    .S_RBS_ACK     (s_ack),
    .S_RBS_RD_WR_L (s_rdwr),
    .S_RBS_ADDR    (s_addr),
    .S_RBS_DATA    (s_data),
    .S_RBS_SRC     (s_src),
    .M_RBS_REQ     (m_req),
    .M_RBS_ACK     (m_ack),
    .M_RBS_RD_WR_L (m_rdwr),
    .M_RBS_ADDR    (m_addr),
    .M_RBS_DATA    (m_data),
    .M_RBS_SRC     (m_src),
    .RW_REGS       (rw_regs),
    .WR_STROBE     (wr_strobe),
    .RO_REGS       (ro_regs),
    .RD_STROBE     (rd_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rw_flat();
    return {rw_m[3], rw_m[2], rw_m[1], rw_m[0]};
  endfunction

  // Check every output against explicit expected values.
  task automatic chk_all(input string tag,
                         input logic e_req, input logic e_ack, input logic e_rdwr,
                         input logic [29:0] e_addr, input logic [31:0] e_data,
                         input logic [1:0] e_src, input logic [3:0] e_wr,
                         input logic [3:0] e_rd);
    chk({tag, ".req"},   128'(m_req),     128'(e_req));
    chk({tag, ".ack"},   128'(m_ack),     128'(e_ack));
    chk({tag, ".rdwr"},  128'(m_rdwr),    128'(e_rdwr));
    chk({tag, ".addr"},  128'(m_addr),    128'(e_addr));
    chk({tag, ".data"},  128'(m_data),    128'(e_data));
    chk({tag, ".src"},   128'(m_src),     128'(e_src));
    chk({tag, ".wrstb"}, 128'(wr_strobe), 128'(e_wr));
    chk({tag, ".rdstb"}, 128'(rd_strobe), 128'(e_rd));
    chk({tag, ".rw"},    rw_regs,         rw_flat());
  endtask

  // Apply one ring word, let it cross one clock edge, and compare the
  // outputs against the model's view of what the node must emit.
  task automatic step(input string tag, input logic req, input logic ack,
                      input logic rdwr, input logic [29:0] addr,
                      input logic [31:0] data, input logic [1:0] src,
                      input logic [127:0] ro);
    int unsigned    off;
    bit             hit;
    logic           e_ack;
    logic [31:0]    e_data;
    logic [3:0]     e_wr;
    logic [3:0]     e_rd;
    logic [127:0]   sh;

    s_req = req; s_ack = ack; s_rdwr = rdwr; s_addr = addr;
    s_data = data; s_src = src; ro_regs = ro;

    off    = int'(addr) % 16;
    hit    = req && !ack && ((int'(addr) / 16) == (int'(BASE) / 16));
    e_ack  = ack | hit;
    e_data = data;
    e_wr   = '0;
    e_rd   = '0;
    if (hit && rdwr) begin
      if (off < NRW) begin
        e_data = rw_m[off];
      end else if (off < NRW + NRO) begin
        sh     = ro >> (32 * (off - NRW));
        e_data = sh[31:0];
        e_rd   = 4'(1 << (off - NRW));
      end else begin
        e_data = 32'hDEAD_BEEF;
      end
    end
    if (hit && !rdwr && off < NRW) begin
      rw_m[off] = data;
      e_wr      = 4'(1 << off);
    end

    @(posedge clk);
    #1;
    chk_all(tag, req, e_ack, rdwr, addr, e_data, src, e_wr, e_rd);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00, 128'h0);
  endtask

  initial begin
    logic [127:0] ro;
    logic [29:0]  a;

    n_assert = 0;
    n_fail   = 0;
    for (int i = 0; i < NRW; i++) rw_m[i] = '0;

    rst_n = 1'b0;
    s_req = 1'b0; s_ack = 1'b0; s_rdwr = 1'b0;
    s_addr = '0; s_data = '0; s_src = '0; ro_regs = '0;

    #1;
    chk_all("reset", 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00, 4'h0, 4'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Write hit: word 2 loaded, WR_STROBE[2] pulses for one cycle.
    step("wr_hit", 1'b1, 1'b0, 1'b0, 30'h102, 32'hF00DFACE, 2'b01, 128'h0);
    chk("wr_hit.word2", 128'(rw_regs[95:64]), 128'(32'hF00DFACE));
    idle("wr_hit.after");

    // Read hit on RO word 1.
    ro = {32'h0, 32'h0, 32'h12345678, 32'h0};
    step("rd_ro1", 1'b1, 1'b0, 1'b1, 30'h105, 32'h0, 2'b10, ro);
    chk("rd_ro1.data", 128'(m_data), 128'(32'h12345678));

    // Miss: forwarded bit-exact, no register change.
    step("miss", 1'b1, 1'b0, 1'b0, 30'h200, 32'h01234567, 2'b11, 128'h0);

    // Already acknowledged request that hits the window.
    step("preack", 1'b1, 1'b1, 1'b1, 30'h101, 32'hAAAA5555, 2'b01, 128'h0);

    // Unmapped read and RO write.
    step("unmapped", 1'b1, 1'b0, 1'b1, 30'h10A, 32'h0, 2'b00, 128'h0);
    chk("unmapped.data", 128'(m_data), 128'(32'hDEADBEEF));
    step("ro_write", 1'b1, 1'b0, 1'b0, 30'h104, 32'h55AA55AA, 2'b00, ro);
    step("unmapped_wr", 1'b1, 1'b0, 1'b0, 30'h10F, 32'h77777777, 2'b00, 128'h0);

    // No request: data still passes through.
    step("noreq", 1'b0, 1'b0, 1'b1, 30'h103, 32'hCAFEBABE, 2'b10, 128'h0);

    // Back-to-back write then read of the same register.
    step("b2b_wr", 1'b1, 1'b0, 1'b0, 30'h103, 32'h13579BDF, 2'b00, 128'h0);
    step("b2b_rd", 1'b1, 1'b0, 1'b1, 30'h103, 32'h0, 2'b01, 128'h0);

    // Random traffic, mostly inside the window.
    for (int i = 0; i < 300; i++) begin
      ro = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = BASE + 30'($urandom_range(0, 15));
      else                           a = 30'($urandom);
      step("rand", ($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
           1'($urandom), a, $urandom, 2'($urandom), ro);
    end

    // Reset in the middle of a write hit to offset 0.
    step("pre_rst", 1'b1, 1'b0, 1'b1, 30'h100, 32'h0, 2'b11, 128'h0);
    s_req = 1'b1; s_ack = 1'b0; s_rdwr = 1'b0;
    s_addr = 30'h100; s_data = 32'h89ABCDEF; s_src = 2'b01;
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NRW; i++) rw_m[i] = '0;
    #1;
    chk_all("rst_async", 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00, 4'h0, 4'h0);
    @(posedge clk);
    #1;
    chk_all("rst_held", 1'b0, 1'b0, 1'b0, 30'h0, 32'h0, 2'b00, 4'h0, 4'h0);
    s_req = 1'b0; s_rdwr = 1'b0; s_addr = '0; s_data = '0; s_src = '0;
    rst_n = 1'b1;
    idle("post_rst");
    step("post_rst_rd0", 1'b1, 1'b0, 1'b1, 30'h100, 32'h0, 2'b00, 128'h0);
    step("post_rst_wr1", 1'b1, 1'b0, 1'b0, 30'h101, 32'h0BADF00D, 2'b10, 128'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
